// File: rtl/decrypt_pkg.sv
// Shared constants and state encoding for the program-3 decrypt/depad sequencer.
package decrypt_pkg;

  localparam logic [7:0]  IN_BASE  = 8'd64;
  localparam logic [7:0]  OUT_BASE = 8'd0;
  localparam int unsigned MSG_LEN  = 64;
  localparam int unsigned PRE_MIN  = 10;
  localparam int unsigned NUM_PTRN = 9;

  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSearch,
    StDecrypt,
    StPad,
    StDone
  } state_e;

endpackage

// File: rtl/decrypt_sequencer_if.sv
// Request/ack handshake plus data-memory read/write ports of the decrypt sequencer.
interface decrypt_sequencer_if;

  logic       req;
  logic       ack;
  logic       pattern_fail;
  logic [3:0] ptrn_idx;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_we;

  // Sequencer side.
  modport slave (
    input  req, mem_rdata,
    output ack, pattern_fail, ptrn_idx, mem_raddr, mem_waddr, mem_wdata, mem_we
  );

  // Host / memory side.
  modport master (
    output req, mem_rdata,
    input  ack, pattern_fail, ptrn_idx, mem_raddr, mem_waddr, mem_wdata, mem_we
  );

endinterface

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR: shifts left, feeding back the parity of the tapped bits.
module lfsr7 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       step_i,
  input  logic [6:0] taps_i,
  output logic [6:0] state_o,
  output logic [6:0] next_o
);

  logic [6:0] state_q;

  assign next_o  = {state_q[5:0], ^(state_q & taps_i)};
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= load_val_i;
    end else if (step_i) begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/decrypt_sequencer.sv
// Recovers the LFSR taps/seed from the space preamble, decrypts DM[64..127], strips
// leading spaces and writes {parity_err, plain} to DM[0..63], space-padding the tail.
module decrypt_sequencer
  import decrypt_pkg::*;
(
  input logic          clk,
  input logic          init_n,
  decrypt_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic       req_q;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] step_q, step_d;
  logic [3:0] p_q, p_d;
  logic [6:0] wptr_q, wptr_d;
  logic       skip_q, skip_d;
  logic       ack_q, ack_d;
  logic       fail_q, fail_d;
  logic [7:0] raddr_q, raddr_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;

  logic [6:0] k_q [PRE_MIN];
  logic       k_we;
  logic [3:0] k_widx;
  logic [6:0] k_wval;

  logic       lfsr_load, lfsr_step;
  logic [6:0] lfsr_state, lfsr_next, taps;
  logic [6:0] plain;
  logic       err, drop;

  // One tap register serves both the search and the decrypt phase.
  assign taps  = LFSR_PTRN[p_q];
  assign plain = bus.mem_rdata[6:0] ^ lfsr_state;
  assign err   = ^bus.mem_rdata;
  assign drop  = skip_q && !err && ({1'b0, plain} == SPACE);

  lfsr7 u_lfsr (
    .clk_i      (clk),
    .rst_ni     (init_n),
    .load_i     (lfsr_load),
    .load_val_i (k_q[0]),
    .step_i     (lfsr_step),
    .taps_i     (taps),
    .state_o    (lfsr_state),
    .next_o     (lfsr_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    p_d       = p_q;
    wptr_d    = wptr_q;
    skip_d    = skip_q;
    fail_d    = fail_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    k_we      = 1'b0;
    k_widx    = cnt_q[3:0] - 4'd1;
    k_wval    = bus.mem_rdata[6:0] ^ SPACE[6:0];
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_q && !bus.req) begin
          state_d = StLoad;
          cnt_d   = '0;
          step_d  = 4'd1;
          p_d     = '0;
          wptr_d  = '0;
          skip_d  = 1'b1;
          fail_d  = 1'b0;
          raddr_d = IN_BASE;
        end
      end

      // Read data trails the address by one cycle, so byte c-1 lands in cycle c.
      StLoad: begin
        k_we    = (cnt_q != '0);
        raddr_d = raddr_q + 8'd1;
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == 7'(PRE_MIN)) begin
          state_d   = StSearch;
          cnt_d     = '0;
          lfsr_load = 1'b1;
        end
      end

      StSearch: begin
        if (k_q[0] == '0) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end else if (lfsr_next == k_q[step_q]) begin
          if (step_q == 4'(PRE_MIN - 1)) begin
            lfsr_load = 1'b1;
            state_d   = StDecrypt;
            cnt_d     = '0;
            raddr_d   = IN_BASE;
          end else begin
            lfsr_step = 1'b1;
            step_d    = step_q + 4'd1;
          end
        end else if (p_q == 4'(NUM_PTRN - 1)) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end else begin
          p_d       = p_q + 4'd1;
          step_d    = 4'd1;
          lfsr_load = 1'b1;
        end
      end

      StDecrypt: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q < 7'(MSG_LEN - 1)) begin
          raddr_d = raddr_q + 8'd1;
        end
        if (cnt_q != '0) begin
          lfsr_step = 1'b1;
          if (!drop) begin
            we_d    = 1'b1;
            waddr_d = OUT_BASE + {1'b0, wptr_q};
            wdata_d = {err, plain};
            wptr_d  = wptr_q + 7'd1;
            skip_d  = 1'b0;
          end
          if (cnt_q == 7'(MSG_LEN)) begin
            state_d = (wptr_d == 7'(MSG_LEN)) ? StDone : StPad;
          end
        end
      end

      StPad: begin
        we_d    = 1'b1;
        waddr_d = OUT_BASE + {1'b0, wptr_q};
        wdata_d = SPACE;
        wptr_d  = wptr_q + 7'd1;
        if (wptr_d == 7'(MSG_LEN)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (bus.req) begin
          state_d = StIdle;
          fail_d  = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase

    // Ack rises one cycle into DONE, after the final registered write has retired.
    ack_d = (state_q == StDone) && (state_d == StDone);
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      step_q  <= '0;
      p_q     <= '0;
      wptr_q  <= '0;
      skip_q  <= 1'b0;
      ack_q   <= 1'b0;
      fail_q  <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      for (int i = 0; i < int'(PRE_MIN); i++) begin
        k_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= bus.req;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      p_q     <= p_d;
      wptr_q  <= wptr_d;
      skip_q  <= skip_d;
      ack_q   <= ack_d;
      fail_q  <= fail_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      if (k_we) begin
        k_q[k_widx] <= k_wval;
      end
    end
  end

  assign bus.ack          = ack_q;
  assign bus.pattern_fail = fail_q;
  assign bus.ptrn_idx     = p_q;
  assign bus.mem_raddr    = raddr_q;
  assign bus.mem_waddr    = waddr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_we       = we_q;

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Directed bench for decrypt_sequencer: encrypts known messages into a model data memory,
// runs the sequencer and compares DM[0..63] and status against hand-written plaintext.
module tb_decrypt_sequencer;

  localparam logic [6:0] TB_PTRN [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  logic clk = 1'b0;
  logic init_n;
  decrypt_sequencer_if bus ();

  decrypt_sequencer dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] exp_dm [64];
  logic [7:0] rdata_q;
  logic       load_stb;
  logic       bad_addr;
  int         wr_cnt;
  int         checks   = 0;
  int         failures = 0;

  always @(posedge clk) begin
    if (load_stb) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wr_cnt   <= 0;
      bad_addr <= 1'b0;
    end else if (bus.mem_we) begin
      mem[bus.mem_waddr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (bus.mem_waddr > 8'd63) bad_addr <= 1'b1;
    end
    rdata_q <= mem[bus.mem_raddr];
  end
  assign bus.mem_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = (i < 64) ? 8'hEE : 8'h00;
  endtask

  // Program-3 encryptor: 7-bit char xor LFSR state, bit 7 makes even parity.
  task automatic build_img(input int pidx, input logic [6:0] init, input int pre,
                           input string msg);
    logic [6:0] s;
    logic [6:0] c7;
    logic [7:0] ch;
    int         m;
    clear_img();
    s = init;
    for (int i = 0; i < 64; i++) begin
      m = i - pre;
      if (i < pre || m >= msg.len()) ch = 8'h20;
      else ch = msg[m];
      c7 = ch[6:0] ^ s;
      img[64 + i] = {^c7, c7};
      s = {s[5:0], ^(s & TB_PTRN[pidx])};
    end
  endtask

  task automatic fill_exp(input string s);
    logic [7:0] ch;
    for (int j = 0; j < 64; j++) begin
      if (j < s.len()) begin
        ch = s[j];
        exp_dm[j] = {1'b0, ch[6:0]};
      end else begin
        exp_dm[j] = 8'h20;
      end
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    load_stb = 1'b1;
    @(negedge clk);
    load_stb = 1'b0;
  endtask

  task automatic do_run(input string tag);
    int cyc;
    bus.req = 1'b1;
    repeat (2) @(negedge clk);
    bus.req = 1'b0;
    cyc = 0;
    while (bus.ack !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ack_within_256"}, 32'(cyc < 256), 1);
  endtask

  task automatic check_status(input string tag, input logic exp_fail, input logic [3:0] exp_idx,
                              input int exp_wr);
    chk({tag, "_pattern_fail"}, bus.pattern_fail, exp_fail);
    if (!exp_fail) chk({tag, "_ptrn_idx"}, bus.ptrn_idx, exp_idx);
    chk({tag, "_write_count"}, wr_cnt, exp_wr);
    chk({tag, "_addr_range"}, bad_addr, 1'b0);
  endtask

  task automatic check_dm(input string tag);
    for (int j = 0; j < 64; j++) chk($sformatf("%s_dm%0d", tag, j), mem[j], exp_dm[j]);
  endtask

  task automatic release_req(input string tag);
    bus.req = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_drop"}, bus.ack, 1'b0);
    chk({tag, "_fail_drop"}, bus.pattern_fail, 1'b0);
  endtask

  string m1 = "Mr. Watson, come here. I want to see you.";
  string m2 = " Knowledge comes, but wisdom lingers.";
  string e2 = "Knowledge comes, but wisdom lingers.";

  initial begin
    int         waited;
    int         snap;
    logic [7:0] t;

    load_stb = 1'b0;
    bus.req  = 1'b1;
    init_n   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.ack, 1'b0);
    chk("rst_pattern_fail", bus.pattern_fail, 1'b0);
    chk("rst_ptrn_idx", bus.ptrn_idx, 4'd0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_raddr", bus.mem_raddr, 8'd0);
    chk("rst_mem_waddr", bus.mem_waddr, 8'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 8'd0);
    init_n = 1'b1;
    @(negedge clk);

    // Pattern 0x60, seed 0x01, 10-space preamble.
    build_img(0, 7'h01, 10, m1);
    load_mem();
    do_run("watson");
    fill_exp(m1);
    check_status("watson", 1'b0, 4'd0, 64);
    check_dm("watson");
    release_req("watson");

    // Last pattern, longer preamble; the message's own leading space is stripped too.
    build_img(8, 7'h7F, 15, m2);
    load_mem();
    do_run("wisdom");
    fill_exp(e2);
    check_status("wisdom", 1'b0, 4'd8, 64);
    chk("wisdom_first_char", mem[0], 8'h4B);
    check_dm("wisdom");
    release_req("wisdom");

    // Parity faults: data-bit flip at byte 30, parity-bit flip at byte 40.
    build_img(0, 7'h01, 10, m1);
    img[64 + 30] = img[64 + 30] ^ 8'h04;
    img[64 + 40] = img[64 + 40] ^ 8'h80;
    load_mem();
    do_run("parity");
    fill_exp(m1);
    t = exp_dm[20];
    exp_dm[20] = {1'b1, t[6:0] ^ 7'h04};
    exp_dm[30] = exp_dm[30] | 8'h80;
    check_status("parity", 1'b0, 4'd0, 64);
    check_dm("parity");
    release_req("parity");

    // All-space message: nothing survives the strip, PAD writes all 64 bytes.
    build_img(0, 7'h01, 10, "");
    load_mem();
    do_run("spaces");
    fill_exp("");
    check_status("spaces", 1'b0, 4'd0, 64);
    check_dm("spaces");
    release_req("spaces");

    // Preamble that is not a keystream of any pattern.
    clear_img();
    for (int i = 0; i < 10; i++) img[64 + i] = 8'(i);
    load_mem();
    do_run("nomatch");
    check_status("nomatch", 1'b1, 4'd0, 0);
    chk("nomatch_dm0_untouched", mem[0], 8'hEE);
    release_req("nomatch");

    // Plaintext-equal preamble gives k[0]=0, an illegal seed.
    clear_img();
    for (int i = 64; i < 128; i++) img[i] = 8'h20;
    load_mem();
    do_run("zeroseed");
    check_status("zeroseed", 1'b1, 4'd0, 0);
    chk("zeroseed_dm0_untouched", mem[0], 8'hEE);
    release_req("zeroseed");

    // Reset mid-run while writes are streaming, then a clean full run.
    build_img(0, 7'h01, 10, m1);
    load_mem();
    repeat (2) @(negedge clk);
    bus.req = 1'b0;
    waited = 0;
    while (wr_cnt < 20 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("midrst_reached_decrypt", 32'(waited < 300), 1);
    chk("midrst_writing_before", bus.mem_we, 1'b1);
    init_n = 1'b0;
    #1;
    chk("midrst_ack_low", bus.ack, 1'b0);
    chk("midrst_we_low", bus.mem_we, 1'b0);
    snap = wr_cnt;
    repeat (3) @(negedge clk);
    chk("midrst_no_writes", wr_cnt, snap);
    init_n = 1'b1;
    build_img(0, 7'h01, 10, m1);
    load_mem();
    do_run("rerun");
    fill_exp(m1);
    check_status("rerun", 1'b0, 4'd0, 64);
    check_dm("rerun");
    release_req("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
